// File: rtl/pe_force_collector.sv
// Gathers force results from NUM_CHANNEL filter FIFOs into one round-robin output stream.
// Define PE_COLLECTOR_STATS_EN to build the per-phase drained_count statistic.

module pe_force_fifo #(
  parameter int WIDTH = 103,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             ready,
  output logic             push_drop
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push;

  // Readiness ignores a same-cycle pop so in_ready never depends on the arbiter.
  assign ready     = (count != CW'(DEPTH));
  assign push      = push_valid & ready;
  assign push_drop = push_valid & ~ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module pe_force_collector #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int NUM_CHANNEL       = 7,
  parameter int FIFO_DEPTH        = 8,
  parameter int AF_THRESH         = 6,
  localparam int FORCE_WIDTH      = 3*DATA_WIDTH + PARTICLE_ID_WIDTH,
  localparam int CH_WIDTH         = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               phase,
  input  logic [NUM_CHANNEL*FORCE_WIDTH-1:0] in_force_data,
  input  logic [NUM_CHANNEL-1:0]             in_force_valid,
  output logic [NUM_CHANNEL-1:0]             in_ready,
  output logic [FORCE_WIDTH-1:0]             out_force_data,
  output logic [CH_WIDTH-1:0]                out_channel,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               back_pressure,
  output logic                               all_buffer_empty,
  output logic                               phase_drained,
  output logic                               overflow_err,
  output logic [15:0]                        drained_count
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {ACTIVE, DRAIN, DONE} state_t;

  logic [NUM_CHANNEL-1:0][FORCE_WIDTH-1:0] fifo_head;
  logic [NUM_CHANNEL-1:0][CNT_W-1:0]       fifo_count;
  logic [NUM_CHANNEL-1:0]                  nonempty, near_full, pop, drop;
  logic [2*NUM_CHANNEL-1:0]                rr_win;
  logic [CH_WIDTH-1:0]                     last_grant, grant;
  logic                                    found, load;
  logic                                    phase_q;
  state_t                                  state;

  for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_ch
    pe_force_fifo #(.WIDTH(FORCE_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_valid(in_force_valid[c]),
      .push_data (in_force_data[c*FORCE_WIDTH +: FORCE_WIDTH]),
      .pop       (pop[c]),
      .head      (fifo_head[c]),
      .count     (fifo_count[c]),
      .ready     (in_ready[c]),
      .push_drop (drop[c])
    );
    assign nonempty[c]  = |fifo_count[c];
    assign near_full[c] = 32'(fifo_count[c]) >= AF_THRESH;
    assign pop[c]       = load && (grant == CH_WIDTH'(c));
  end

  assign back_pressure    = |near_full;
  assign all_buffer_empty = ~(|nonempty) & ~out_valid;
  assign load             = (~out_valid | out_ready) & (|nonempty);

  function automatic logic [CH_WIDTH-1:0] wrap_add(input logic [CH_WIDTH-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CHANNEL) s = s - NUM_CHANNEL;
    return CH_WIDTH'(s);
  endfunction

  // Rotate the request vector so bit 0 is the channel right after last_grant.
  always_comb begin
    rr_win = {nonempty, nonempty} >> (32'(last_grant) + 1);
    grant  = last_grant;
    found  = 1'b0;
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      if (!found && rr_win[i]) begin
        found = 1'b1;
        grant = wrap_add(last_grant, i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      out_force_data <= fifo_head[grant];
      out_channel    <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      last_grant    <= CH_WIDTH'(NUM_CHANNEL - 1);
      overflow_err  <= 1'b0;
      phase_q       <= phase;
      state         <= ACTIVE;
      phase_drained <= 1'b0;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        last_grant <= grant;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
      if (|drop) overflow_err <= 1'b1;
      phase_q       <= phase;
      phase_drained <= 1'b0;
      case (state)
        ACTIVE: if (phase != phase_q) state <= DRAIN;
        DRAIN: begin
          if (all_buffer_empty) begin
            state         <= DONE;
            phase_drained <= 1'b1;
          end
        end
        default: state <= ACTIVE;
      endcase
    end
  end

`ifdef PE_COLLECTOR_STATS_EN
  logic [15:0] drain_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                         drain_cnt <= '0;
    else if (state == DRAIN && all_buffer_empty)     drain_cnt <= '0;
    else if (out_valid && out_ready && drain_cnt != 16'hFFFF)
                                                     drain_cnt <= drain_cnt + 1'b1;
  end

  assign drained_count = drain_cnt;
`else
  assign drained_count = '0;
`endif
endmodule

// File: tb/tb_pe_force_collector.sv
// Directed + randomized bench for pe_force_collector against a queue-based reference model.
// Honors PE_COLLECTOR_STATS_EN when checking drained_count.

module tb_pe_force_collector;
  localparam int N = 7, DW = 32, IDW = 7, FW = 3*DW + IDW, DEPTH = 8, AF = 6, CHW = 3;

  logic            clk = 1'b0;
  logic            rst, phase, out_ready;
  logic [N*FW-1:0] in_force_data;
  logic [N-1:0]    in_force_valid, in_ready;
  logic [FW-1:0]   out_force_data;
  logic [CHW-1:0]  out_channel;
  logic            out_valid, back_pressure, all_buffer_empty, phase_drained, overflow_err;
  logic [15:0]     drained_count;

  always #5 clk = ~clk;

  pe_force_collector dut (
    .clk(clk), .rst(rst), .phase(phase),
    .in_force_data(in_force_data), .in_force_valid(in_force_valid), .in_ready(in_ready),
    .out_force_data(out_force_data), .out_channel(out_channel), .out_valid(out_valid),
    .out_ready(out_ready), .back_pressure(back_pressure), .all_buffer_empty(all_buffer_empty),
    .phase_drained(phase_drained), .overflow_err(overflow_err), .drained_count(drained_count)
  );

  int vecs = 0, errs = 0;

  // Reference model: one queue per channel, plus the output register and drain sequencing.
  logic [FW-1:0] mq [N][$];
  bit            m_ov, m_pq, m_pd, m_ovf;
  logic [FW-1:0] m_od;
  int            m_och, m_last, m_st, m_dc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit abe, hs;
    int g, c;
    bit [N-1:0] full;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_ov = 0; m_last = N - 1; m_st = 0; m_pq = phase; m_pd = 0; m_ovf = 0; m_dc = 0;
      return;
    end
    abe = !m_ov;
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() != 0) abe = 0;
      full[i] = (mq[i].size() == DEPTH);
    end
    hs = m_ov && out_ready;
    g = -1;
    if (!m_ov || out_ready)
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
    if (g >= 0) begin
      m_od = mq[g].pop_front(); m_och = g; m_last = g; m_ov = 1;
    end else if (out_ready) m_ov = 0;
    for (int i = 0; i < N; i++)
      if (in_force_valid[i]) begin
        if (full[i]) m_ovf = 1;
        else mq[i].push_back(in_force_data[i*FW +: FW]);
      end
    m_pd = 0;
    case (m_st)
      0: if (phase != m_pq) m_st = 1;
      1: if (abe) begin m_st = 2; m_pd = 1; end
      default: m_st = 0;
    endcase
    m_pq = phase;
`ifdef PE_COLLECTOR_STATS_EN
    if (m_pd) m_dc = 0;
    else if (hs && m_dc < 65535) m_dc++;
`else
    m_dc = 0;
`endif
  endtask

  task automatic compare_all();
    logic [N-1:0] er;
    bit bp, abe;
    bp = 0; abe = !m_ov;
    for (int i = 0; i < N; i++) begin
      er[i] = (mq[i].size() != DEPTH);
      if (mq[i].size() >= AF) bp = 1;
      if (mq[i].size() != 0) abe = 0;
    end
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_force_data", out_force_data, m_od);
      chk("out_channel", out_channel, m_och);
    end
    chk("in_ready", in_ready, er);
    chk("back_pressure", back_pressure, bp);
    chk("all_buffer_empty", all_buffer_empty, abe);
    chk("phase_drained", phase_drained, m_pd);
    chk("overflow_err", overflow_err, m_ovf);
    chk("drained_count", drained_count, 16'(m_dc));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clr();
    in_force_valid = '0;
    in_force_data  = '0;
  endtask

  task automatic wr(input int c, input logic [FW-1:0] d);
    in_force_valid[c] = 1'b1;
    in_force_data[c*FW +: FW] = d;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic logic [FW-1:0] rnd_force();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[FW-1:0];
  endfunction

  initial begin
    logic [FW-1:0] f42, first;
    logic [FW-1:0] acc [$];
    int exp43 [6];
    int pd_exp [6];
    int pulses, fifo_n;

    phase = 1'b0; out_ready = 1'b1;
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_abe", all_buffer_empty, 1);
    chk("rst_in_ready", in_ready, 7'h7f);
    chk("rst_overflow", overflow_err, 0);
    chk("rst_drained_count", drained_count, 0);
    chk("rst_phase_drained", phase_drained, 0);

    // Single write on channel 3: visible one edge after acceptance
    f42 = {7'd5, 32'd3, 32'd2, 32'd1};
    wr(3, f42);
    tick(); clr();
    chk("lat_edge_k", out_valid, 0);
    tick();
    chk("lat_edge_k1", out_valid, 1);
    chk("lat_channel", out_channel, 3);
    chk("lat_data", out_force_data, f42);
    tick();
    chk("lat_abe", all_buffer_empty, 1);

    // Round-robin order over channels 0, 2, 6
    do_reset();
    exp43 = '{0, 2, 6, 0, 2, 6};
    repeat (2) begin
      wr(0, rnd_force()); wr(2, rnd_force()); wr(6, rnd_force());
      tick(); clr();
    end
    for (int i = 0; i < 6; i++) begin
      chk("rr_valid", out_valid, 1);
      chk("rr_channel", out_channel, exp43[i]);
      tick();
    end
    chk("rr_abe", all_buffer_empty, 1);

    // Fill channel 1 with out_ready low; the first write moves into the output register
    do_reset();
    out_ready = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      f42 = rnd_force();
      if (n == 1) first = f42;
      else if (n <= 9) acc.push_back(f42);
      wr(1, f42);
      tick(); clr();
      if (n >= 2) begin
        fifo_n = (n - 1 > DEPTH) ? DEPTH : n - 1;
        chk("fill_bp", back_pressure, fifo_n >= AF);
        chk("fill_ready", in_ready[1], fifo_n != DEPTH);
        chk("fill_ovf", overflow_err, n == 10);
        chk("fill_head", out_force_data, first);
      end
    end

    // Stall then release: held stable, then one entry per cycle in write order
    repeat (5) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_force_data, first);
      chk("stall_channel", out_channel, 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("release_valid", out_valid, 1);
      chk("release_data", out_force_data, acc[i]);
    end
    tick();
    chk("release_empty", out_valid, 0);

    // Phase drain with 4 entries queued
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) wr(c, rnd_force());
    tick(); clr();
    tick();
    out_ready = 1'b1;
    phase = ~phase;
    pd_exp = '{0, 0, 0, 0, 1, 0};
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (phase_drained) pulses++;
      chk("drain_pd", phase_drained, pd_exp[i]);
`ifdef PE_COLLECTOR_STATS_EN
      if (i == 3) chk("drain_count_before", drained_count, 4);
      if (i == 4) chk("drain_count_after", drained_count, 0);
`endif
    end
    chk("drain_pulses", pulses, 1);

    // Reset mid-transfer discards everything
    out_ready = 1'b0;
    for (int c = 0; c < N; c++) wr(c, rnd_force());
    tick(); tick(); clr();
    do_reset();
    chk("midrst_abe", all_buffer_empty, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 7'h7f);

    // Randomized traffic: light then heavy back-pressure, occasional phase flips
    for (int i = 0; i < 600; i++) begin
      in_force_valid = 7'($urandom) & 7'($urandom);
      for (int c = 0; c < N; c++) in_force_data[c*FW +: FW] = rnd_force();
      out_ready = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) phase = ~phase;
      tick();
    end
    clr();
    out_ready = 1'b1;
    repeat (70) tick();
    chk("final_abe", all_buffer_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
